// File: rtl/matrix_capture_pkg.sv
// Shared definitions for the LED panel capture block. The default panel
// geometry matches the display driver that produces the panel signals.
package matrix_capture_pkg;

    localparam int MC_DISP_ADDR_WIDTH = 3;
    localparam int MC_DISPLAY_WIDTH   = 416;
    localparam int MC_FB_ADDR_WIDTH   = 13;
    localparam int MC_DATA_WIDTH      = 8;

    typedef enum logic [1:0] {
        RMW_IDLE = 2'd0,
        RMW_RD   = 2'd1,
        RMW_WR   = 2'd2
    } rmw_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a history flop. It gives the
// synchronised level of each bit and a one-cycle rising-edge pulse.
module sync_edge
    import matrix_capture_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_hist;

    // Metastability chain plus one cycle of history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_hist <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;

endmodule

// File: rtl/matrix_capture.sv
// Receiver for the shift/latch/row-address LED panel interface. Rebuilds the
// grayscale framebuffer one bit plane at a time via read-modify-write.
module matrix_capture
    import matrix_capture_pkg::*;
#(
    parameter int DISP_ADDR_WIDTH = MC_DISP_ADDR_WIDTH,
    parameter int DISPLAY_WIDTH   = MC_DISPLAY_WIDTH,
    parameter int FB_ADDR_WIDTH   = MC_FB_ADDR_WIDTH,
    parameter int DATA_WIDTH      = MC_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       panel_clk,
    input  logic                       panel_data,
    input  logic                       panel_latch,
    input  logic [DISP_ADDR_WIDTH-1:0] panel_addr,
    output logic [FB_ADDR_WIDTH-1:0]   fb_rd_addr,
    input  logic [DATA_WIDTH-1:0]      fb_rd_data,
    output logic                       fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0]   fb_wr_addr,
    output logic [DATA_WIDTH-1:0]      fb_wr_data,
    output logic                       frame_strobe,
    output logic                       sync_err,
    output logic                       line_err
);

    localparam int X_WIDTH     = $clog2(DISPLAY_WIDTH + 1);
    localparam int PLANE_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [X_WIDTH-1:0]         X_FULL     = X_WIDTH'(DISPLAY_WIDTH);
    localparam logic [PLANE_WIDTH-1:0]     PLANE_LAST = PLANE_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DISP_ADDR_WIDTH-1:0] ROW_LAST   = '1;

    logic                       w_clk_rise;
    logic                       w_latch_rise;
    logic                       w_clk_sync_unused;
    logic                       w_latch_sync;
    logic                       w_data_sync;
    logic [DISP_ADDR_WIDTH-1:0] w_addr_sync;
    logic [DISP_ADDR_WIDTH:0]   w_bus_rise_unused;
    logic                       w_data_edge;
    logic                       w_accept;
    logic [FB_ADDR_WIDTH-1:0]   w_pix_addr;
    logic [DATA_WIDTH-1:0]      w_merged;

    logic [X_WIDTH-1:0]         r_x;
    logic [PLANE_WIDTH-1:0]     r_plane;
    logic [DISP_ADDR_WIDTH-1:0] r_row;
    logic                       r_locked;
    logic                       r_sync_err;
    logic                       r_line_err;
    logic                       r_strobe;

    rmw_state_t                 r_state;
    logic [FB_ADDR_WIDTH-1:0]   r_rd_addr;
    logic                       r_wr_en;
    logic [FB_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic                       r_rmw_bit;
    logic [PLANE_WIDTH-1:0]     r_rmw_plane;

    sync_edge #(.WIDTH(2)) u_ctl_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async ({panel_latch, panel_clk}),
        .o_sync  ({w_latch_sync, w_clk_sync_unused}),
        .o_rise  ({w_latch_rise, w_clk_rise})
    );

    sync_edge #(.WIDTH(DISP_ADDR_WIDTH + 1)) u_bus_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async ({panel_addr, panel_data}),
        .o_sync  ({w_addr_sync, w_data_sync}),
        .o_rise  (w_bus_rise_unused)
    );

    // A shift-clock edge while the latch is high is the latch-hold edge, not data
    assign w_data_edge = w_clk_rise & ~w_latch_sync;
    assign w_accept    = w_data_edge & (r_x != X_FULL);
    assign w_pix_addr  = FB_ADDR_WIDTH'(32'(r_row) * 32'(DISPLAY_WIDTH) + 32'(r_x));

    // Column/plane/row tracking, row prediction and the sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x        <= '0;
            r_plane    <= '0;
            r_row      <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
            r_line_err <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_data_edge) begin
                if (r_x == X_FULL) begin
                    r_line_err <= 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            if (w_latch_rise) begin
                if (r_x != X_FULL) begin
                    r_line_err <= 1'b1;
                end
                if (w_addr_sync == r_row) begin
                    if (r_plane == PLANE_LAST) begin
                        r_plane <= '0;
                        r_row   <= r_row + 1'b1;
                        if (r_row == ROW_LAST) begin
                            r_strobe <= 1'b1;
                        end
                    end else begin
                        r_plane <= r_plane + 1'b1;
                    end
                end else begin
                    if (r_locked) begin
                        r_sync_err <= 1'b1;
                    end
                    r_locked <= 1'b1;
                    r_plane  <= '0;
                    r_row    <= (r_plane == PLANE_LAST) ? w_addr_sync + 1'b1 : w_addr_sync;
                end
                r_x <= '0;
            end
        end
    end

    // Plane 0 writes directly; later planes read, then merge one bit and write back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RMW_IDLE;
            r_rd_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rmw_bit   <= 1'b0;
            r_rmw_plane <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                RMW_RD: begin
                    r_state   <= RMW_WR;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_rd_addr;
                end
                default: r_state <= RMW_IDLE;
            endcase
            if (w_accept) begin
                if (r_plane == '0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_pix_addr;
                    r_wr_data <= {{(DATA_WIDTH-1){1'b0}}, w_data_sync};
                end else begin
                    r_state     <= RMW_RD;
                    r_rd_addr   <= w_pix_addr;
                    r_rmw_bit   <= w_data_sync;
                    r_rmw_plane <= r_plane;
                end
            end
        end
    end

    // Read data only arrives in the write cycle, so the merge is combinational
    always_comb begin
        w_merged              = fb_rd_data;
        w_merged[r_rmw_plane] = r_rmw_bit;
    end

    assign fb_rd_addr   = r_rd_addr;
    assign fb_wr_en     = r_wr_en;
    assign fb_wr_addr   = r_wr_addr;
    assign fb_wr_data   = (r_state == RMW_WR) ? w_merged : r_wr_data;
    assign frame_strobe = r_strobe;
    assign sync_err     = r_sync_err;
    assign line_err     = r_line_err;

endmodule
